// File: rtl/rf_host_port.sv
// Host-side command port for the register file: streams words in (LOAD),
// streams words out (DUMP) or zero-fills (CLEAR) a wrapping address window.
module rf_host_port #(
    parameter int DW   = 64,
    parameter int AW   = 3,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW:0]   cmd_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          done,
    output logic          err,
    output logic          rf_wena,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [AW-1:0] rf_r0addr,
    input  logic [DW-1:0] rf_r0data
);

    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, DUMP, FIN} state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_DUMP  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [AW:0] NREG_L  = (AW+1)'(NREG);

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          wena_q, wena_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [AW-1:0] cur_addr;
    logic          cmd_bad;

    // cnt_q counts elements issued; the address wraps naturally in AW bits
    assign cur_addr = base_q + cnt_q[AW-1:0];
    assign cmd_bad  = (cmd_op == 2'b11) || (cmd_len > NREG_L);

    assign cmd_ready = (state_q == IDLE);
    assign in_ready  = (state_q == LOAD) && (cnt_q != len_q);
    assign done      = (state_q == FIN);
    assign err       = (state_q == FIN) && err_q;
    assign rf_wena   = wena_q;
    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    // In IDLE the read port looks at the offered base so a DUMP can prefetch at the command edge
    assign rf_r0addr = (state_q == IDLE) ? (cmd_valid ? cmd_base : '0) : cur_addr;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        wena_d      = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    base_d = cmd_base;
                    len_d  = cmd_len;
                    cnt_d  = '0;
                    err_d  = cmd_bad;
                    if (cmd_bad || (cmd_len == '0)) begin
                        state_d = FIN;
                    end else begin
                        case (cmd_op)
                            OP_LOAD:  state_d = LOAD;
                            OP_CLEAR: state_d = CLEAR;
                            OP_DUMP: begin
                                state_d     = DUMP;
                                out_valid_d = 1'b1;
                                out_data_d  = rf_r0data;
                                out_last_d  = (cmd_len == (AW+1)'(1));
                                cnt_d       = (AW+1)'(1);
                            end
                            default: state_d = FIN;
                        endcase
                    end
                end
            end
            // The extra cycle with cnt_q == len_q lets the last registered write drain before FIN
            LOAD: begin
                if (in_valid && in_ready) begin
                    wena_d  = 1'b1;
                    waddr_d = cur_addr;
                    wdata_d = in_data;
                    cnt_d   = cnt_q + 1'b1;
                end else if (cnt_q == len_q) begin
                    state_d = FIN;
                end
            end
            CLEAR: begin
                if (cnt_q != len_q) begin
                    wena_d  = 1'b1;
                    waddr_d = cur_addr;
                    wdata_d = '0;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    state_d = FIN;
                end
            end
            DUMP: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = FIN;
                end else if ((!out_valid_q || out_ready) && (cnt_q != len_q)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rf_r0data;
                    out_last_d  = (cnt_q == (len_q - 1'b1));
                    cnt_d       = cnt_q + 1'b1;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            FIN: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            wena_q      <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            wena_q      <= wena_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_rf_host_port.sv
// Directed bench for rf_host_port: a simple register-file model on the RF ports,
// a vector table for command outcomes and hand sequences for data and reset cases.
module tb_rf_host_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_base;
    logic [3:0]  cmd_len;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        done;
    logic        err;
    logic        rf_wena;
    logic [2:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [2:0]  rf_r0addr;
    logic [63:0] rf_r0data;

    int tests = 0;
    int fails = 0;

    logic [63:0] rf_mem [8] = '{default: 64'h0};
    logic [63:0] exp_rf [8];
    logic [63:0] load_vec [8];
    logic [63:0] words_q [$];
    logic        lasts_q [$];

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] base;
        logic [3:0] len;
        logic [3:0] vpat;
        logic [3:0] rpat;
        int         exp_cyc;
        logic       exp_err;
        int         exp_wr;
        int         exp_words;
    } vec_t;

    vec_t vecs [8];

    rf_host_port #(.DW(64), .AW(3), .NREG(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .err       (err),
        .rf_wena   (rf_wena),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_r0addr (rf_r0addr),
        .rf_r0data (rf_r0data)
    );

    always #5 clk = ~clk;

    assign rf_r0data = rf_mem[rf_r0addr];

    always @(posedge clk) begin
        if (rf_wena) rf_mem[rf_waddr] <= rf_wdata;
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, then drive the streams cycle by cycle from the two
    // 4-bit patterns until done is seen; cycles are numbered from the command edge.
    task automatic apply_stimulus(input logic [1:0] op, input logic [2:0] base, input logic [3:0] len,
                                  input logic [3:0] vpat, input logic [3:0] rpat,
                                  output int cyc, output int nwr, output int ndone, output logic err_seen);
        int          nin;
        logic        stalled;
        logic [63:0] held;
        words_q.delete();
        lasts_q.delete();
        cyc = 0; nwr = 0; ndone = 0; err_seen = 1'b0; nin = 0; stalled = 1'b0; held = '0;
        cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len;
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (rf_wena) nwr++;
            if (done) begin
                ndone++;
                cyc = k;
                err_seen = err;
            end
            if (stalled) begin
                check_output("stall_valid", 64'(out_valid), 64'd1);
                check_output("stall_data", out_data, held);
            end
            in_valid  = vpat[(k-1)%4];
            in_data   = load_vec[nin % 8];
            out_ready = rpat[(k-1)%4];
            if (in_valid && in_ready) nin++;
            if (out_valid && out_ready) begin
                words_q.push_back(out_data);
                lasts_q.push_back(out_last);
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            step();
            if (ndone > 0) break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_output("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic check_words(input string name, input logic [2:0] base, input int len);
        for (int i = 0; i < words_q.size(); i++) begin
            check_output($sformatf("%s_word%0d", name, i), words_q[i], exp_rf[3'(base + 3'(i))]);
            check_output($sformatf("%s_last%0d", name, i), 64'(lasts_q[i]), 64'(i == len - 1));
        end
    endtask

    task automatic check_rf(input string name);
        for (int i = 0; i < 8; i++)
            check_output($sformatf("%s_rf%0d", name, i), rf_mem[i], exp_rf[i]);
    endtask

    initial begin
        int   cyc, nwr, ndone;
        logic err_seen;
        logic saw_done;

        // op, base, len, vpat, rpat, exp_cyc, exp_err, exp_wr, exp_words
        vecs[0] = '{2'd0, 3'd5, 4'd3, 4'b0101, 4'b1111, 7, 1'b0, 3, 0};
        vecs[1] = '{2'd1, 3'd3, 4'd1, 4'b1111, 4'b1111, 2, 1'b0, 0, 1};
        vecs[2] = '{2'd3, 3'd0, 4'd2, 4'b1111, 4'b1111, 1, 1'b1, 0, 0};
        vecs[3] = '{2'd0, 3'd0, 4'd9, 4'b1111, 4'b1111, 1, 1'b1, 0, 0};
        vecs[4] = '{2'd1, 3'd2, 4'd0, 4'b1111, 4'b1111, 1, 1'b0, 0, 0};
        vecs[5] = '{2'd2, 3'd4, 4'd0, 4'b1111, 4'b1111, 1, 1'b0, 0, 0};
        vecs[6] = '{2'd1, 3'd0, 4'd9, 4'b1111, 4'b1111, 1, 1'b1, 0, 0};
        vecs[7] = '{2'd0, 3'd7, 4'd2, 4'b1111, 4'b1111, 4, 1'b0, 2, 0};

        for (int i = 0; i < 8; i++) exp_rf[i] = '0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_base = '0; cmd_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step();
        step();
        check_output("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_output("rst_in_ready", 64'(in_ready), 64'd0);
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_out_last", 64'(out_last), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_err", 64'(err), 64'd0);
        check_output("rst_wena", 64'(rf_wena), 64'd0);
        check_output("rst_waddr", 64'(rf_waddr), 64'd0);
        check_output("rst_r0addr", 64'(rf_r0addr), 64'd0);
        check_output("rst_wdata", rf_wdata, 64'd0);
        check_output("rst_out_data", out_data, 64'd0);
        rst = 1'b0;
        step();

        // Fill RF[i] = i*0x100
        for (int i = 0; i < 8; i++) begin
            load_vec[i] = 64'(i) * 64'h100;
            exp_rf[i]   = 64'(i) * 64'h100;
        end
        apply_stimulus(2'd0, 3'd0, 4'd8, 4'b1111, 4'b1111, cyc, nwr, ndone, err_seen);
        check_output("fill_cyc", 64'(cyc), 64'd10);
        check_output("fill_wr", 64'(nwr), 64'd8);
        check_rf("fill");

        load_vec[0] = 64'h11; load_vec[1] = 64'h22; load_vec[2] = 64'h33; load_vec[3] = 64'h44;
        apply_stimulus(2'd0, 3'd2, 4'd4, 4'b1111, 4'b1111, cyc, nwr, ndone, err_seen);
        exp_rf[2] = 64'h11; exp_rf[3] = 64'h22; exp_rf[4] = 64'h33; exp_rf[5] = 64'h44;
        check_output("load_cyc", 64'(cyc), 64'd6);
        check_output("load_wr", 64'(nwr), 64'd4);
        check_output("load_done", 64'(ndone), 64'd1);
        check_output("load_err", 64'(err_seen), 64'd0);
        check_rf("load");

        apply_stimulus(2'd1, 3'd6, 4'd4, 4'b1111, 4'b1111, cyc, nwr, ndone, err_seen);
        check_output("dwrap_cyc", 64'(cyc), 64'd5);
        check_output("dwrap_words", 64'(words_q.size()), 64'd4);
        check_output("dwrap_wr", 64'(nwr), 64'd0);
        check_words("dwrap", 3'd6, 4);
        if (words_q.size() == 4) begin
            check_output("dwrap_w2_lit", words_q[2], 64'h000);
            check_output("dwrap_w3_lit", words_q[3], 64'h100);
        end

        apply_stimulus(2'd1, 3'd0, 4'd8, 4'b1111, 4'b1001, cyc, nwr, ndone, err_seen);
        check_output("dstall_done", 64'(ndone), 64'd1);
        check_output("dstall_words", 64'(words_q.size()), 64'd8);
        check_words("dstall", 3'd0, 8);

        for (int i = 0; i < 8; i++) load_vec[i] = 64'hA0 + 64'(i);
        for (int v = 0; v < 8; v++) begin
            apply_stimulus(vecs[v].op, vecs[v].base, vecs[v].len, vecs[v].vpat, vecs[v].rpat,
                           cyc, nwr, ndone, err_seen);
            check_output($sformatf("vec%0d_cyc", v), 64'(cyc), 64'(vecs[v].exp_cyc));
            check_output($sformatf("vec%0d_err", v), 64'(err_seen), 64'(vecs[v].exp_err));
            check_output($sformatf("vec%0d_wr", v), 64'(nwr), 64'(vecs[v].exp_wr));
            check_output($sformatf("vec%0d_words", v), 64'(words_q.size()), 64'(vecs[v].exp_words));
            if (vecs[v].op == 2'd1) check_words($sformatf("vec%0d", v), vecs[v].base, int'(vecs[v].len));
            if (vecs[v].op == 2'd0 && !vecs[v].exp_err)
                for (int i = 0; i < int'(vecs[v].len); i++)
                    exp_rf[3'(vecs[v].base + 3'(i))] = load_vec[i];
        end
        check_rf("table");

        apply_stimulus(2'd2, 3'd7, 4'd2, 4'b1111, 4'b1111, cyc, nwr, ndone, err_seen);
        exp_rf[7] = '0; exp_rf[0] = '0;
        check_output("clear_cyc", 64'(cyc), 64'd4);
        check_output("clear_wr", 64'(nwr), 64'd2);
        check_output("clear_words", 64'(words_q.size()), 64'd0);
        check_rf("clear");

        // Reset after two of four LOAD words
        saw_done = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_base = 3'd0; cmd_len = 4'd4;
        step();
        cmd_valid = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (done) saw_done = 1'b1;
            in_data = 64'hF0 + 64'(k);
            if (k == 2) rst = 1'b1;
            step();
        end
        check_output("abort_wena", 64'(rf_wena), 64'd0);
        check_output("abort_done", 64'(done), 64'd0);
        check_output("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        if (done) saw_done = 1'b1;
        check_output("abort_wena_next", 64'(rf_wena), 64'd0);
        check_output("abort_no_done", 64'(saw_done), 64'd0);
        check_output("abort_ready_next", 64'(cmd_ready), 64'd1);
        exp_rf[0] = 64'hF0; exp_rf[1] = 64'hF1;
        check_rf("abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_host_port.md
RF_HOST_PORT -- requirements
Module: rf_host_port

Interface
REQ-001 SHALL have parameters: DW, 64, register data width; AW, 3, register address width; NREG, 8, register count (2**AW).
REQ-002 SHALL have ports (name  direction  width  meaning):
 - clk  in  1  clock, all state updates on rising edge
 - rst  in  1  reset, synchronous, active-high
 - cmd_valid  in  1  command offered
 - cmd_ready  out  1  command accepted when high with cmd_valid
 - cmd_op  in  2  00 LOAD, 01 DUMP, 10 CLEAR, 11 illegal
 - cmd_base  in  AW  first register address
 - cmd_len  in  AW+1  register count, 0..NREG
 - in_valid  in  1  load-stream word offered
 - in_ready  out  1  load-stream word accepted when high with in_valid
 - in_data  in  DW  load-stream word
 - out_valid  out  1  dump-stream word offered
 - out_ready  in  1  dump-stream sink accepts
 - out_data  out  DW  dump-stream word
 - out_last  out  1  final word of a dump
 - done  out  1  one-cycle pulse, command complete
 - err  out  1  one-cycle pulse with done, illegal op or len > NREG
 - rf_wena  out  1  register-file write enable
 - rf_waddr  out  AW  register-file write address
 - rf_wdata  out  DW  register-file write data
 - rf_r0addr  out  AW  register-file read port 0 address
 - rf_r0data  in  DW  register-file read port 0 data, combinational from rf_r0addr
REQ-003 SHALL use only the write port and read port 0 of the register file; read port 1 is left to the datapath.

Function
REQ-004 SHALL implement states IDLE, LOAD, CLEAR, DUMP, FIN.
REQ-005 cmd_ready SHALL be 1 only in IDLE; a command is captured on the edge where cmd_valid and cmd_ready are both 1.
REQ-006 From IDLE: op LOAD -> LOAD, DUMP -> DUMP, CLEAR -> CLEAR; illegal op, cmd_len == 0 or cmd_len > NREG -> FIN with err (err not asserted for len 0).
REQ-007 Register address for element i SHALL be (cmd_base + i) mod NREG; wrap from 7 to 0 is required behaviour.
REQ-008 LOAD: in_ready = 1; each in handshake registers rf_wena=1, rf_waddr=addr(i), rf_wdata=in_data, so the RF write occurs at the edge following the handshake edge; after handshake len-1, state -> FIN.
REQ-009 rf_wena SHALL be 1 for exactly one cycle per accepted word and 0 at all other times; in_valid low inserts gaps with no write.
REQ-010 CLEAR: one registered write of 0 per cycle to addr(0..len-1), no stream traffic; after element len-1 is issued, state -> FIN.
REQ-011 DUMP: rf_r0addr = addr(next); out_data/out_valid form a one-entry output register loaded from rf_r0data when (!out_valid || out_ready) and elements remain; sustained throughput one word per cycle with out_ready held high.
REQ-012 out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-013 out_last SHALL be 1 with out_valid on element len-1 only; its handshake moves state -> FIN.
REQ-014 FIN lasts one cycle: done = 1 (err = 1 if flagged), rf_wena = 0, then IDLE.
REQ-015 in_ready SHALL be 0 outside LOAD; out_valid SHALL be 0 outside DUMP; in_data and out_ready are ignored elsewhere.
REQ-016 Latency: LOAD len N with in_valid held high -> done in cycle N+2 after command edge; DUMP len N with out_ready held high -> first out_valid cycle 1, done cycle N+1.

Reset
REQ-017 On rst: state IDLE; cmd_ready 1 in the following cycle; in_ready, out_valid, out_last, done, err, rf_wena 0; rf_waddr, rf_r0addr 0; rf_wdata, out_data 0; counters 0.
REQ-018 rst mid-operation SHALL abort the command with no done pulse, and no RF write SHALL be issued in the cycle after the reset edge.

Verification
REQ-019 LOAD base 2 len 4 data 0x11,0x22,0x33,0x44 -> RF[2..5] = those values, 4 single-cycle rf_wena pulses, done once.
REQ-020 DUMP base 6 len 4 after loading RF[i]=i*0x100 -> out stream 0x600,0x700,0x000,0x100, out_last on 0x100 (wrap check).
REQ-021 DUMP len 8 with out_ready toggling 1,0,0,1 -> no word lost or duplicated, out_data stable while stalled.
REQ-022 CLEAR base 7 len 2 -> RF[7], RF[0] = 0, others unchanged, done after 2 write cycles.
REQ-023 cmd_op 11 or cmd_len 9 -> done and err pulse one cycle after command edge, no rf_wena, no stream traffic.
REQ-024 rst asserted after 2 of 4 LOAD words -> rf_wena 0 from the cycle after the reset edge, no done, cmd_ready 1 in the following cycle.
